// File: rtl/sm_controller_ws.sv
// Eight-phase accumulator-CPU control sequencer with memory wait states,
// a bounded-wait timeout and a resumable halt state.
module sm_controller_ws #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       resume,
   output logic       mem_rd,
   output logic       load_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       load_ac,
   output logic       load_pc,
   output logic       mem_wr,
   output logic [2:0] phase,
   output logic       stall,
   output logic       timeout
);

   localparam logic [3:0] S_INST_ADDR  = 4'd0;
   localparam logic [3:0] S_INST_FETCH = 4'd1;
   localparam logic [3:0] S_INST_LOAD  = 4'd2;
   localparam logic [3:0] S_IDLE       = 4'd3;
   localparam logic [3:0] S_OP_ADDR    = 4'd4;
   localparam logic [3:0] S_OP_FETCH   = 4'd5;
   localparam logic [3:0] S_ALU_OP     = 4'd6;
   localparam logic [3:0] S_STORE      = 4'd7;
   localparam logic [3:0] S_HALTED     = 4'd8;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

   logic [3:0]       state;
   logic [3:0]       state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             timeout_q;
   logic             timeout_nxt;
   logic             aluop;
   logic             access;
   logic [3:0]       state_inc;

   assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

   // Memory handshake: the controller presents an access for as long as it
   // sits in an access phase; the access completes on the first rising edge
   // where mem_ready is high, and only then does the phase advance.
   assign access = (state == S_INST_FETCH) ||
                   ((state == S_OP_FETCH) && aluop) ||
                   ((state == S_STORE) && (opcode == OP_STO));

   assign state_inc = {1'b0, state[2:0] + 3'd1};

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      timeout_nxt  = timeout_q;
      if (state == S_HALTED) begin
         if (!timeout_q && resume) begin
            state_nxt = S_INST_ADDR;
         end
      end else if (access) begin
         if (mem_ready) begin
            state_nxt = state_inc;
         end else if (wait_cnt == WAIT_LAST) begin
            state_nxt   = S_HALTED;
            timeout_nxt = 1'b1;
         end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
         end
      end else if ((state == S_OP_ADDR) && (opcode == OP_HLT)) begin
         state_nxt = S_HALTED;
      end else begin
         state_nxt = state_inc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_INST_ADDR;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Strobes are a pure function of the phase (plus opcode/zero), so they
   // stay put for the whole time a phase is stalled.
   always_comb begin
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      case (state)
         S_INST_FETCH: mem_rd = 1'b1;
         S_INST_LOAD, S_IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         S_OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
         end
         S_OP_FETCH: mem_rd = aluop;
         S_ALU_OP: begin
            mem_rd  = aluop;
            load_ac = aluop;
            inc_pc  = (opcode == OP_SKZ) && zero;
            load_pc = (opcode == OP_JMP);
         end
         S_STORE: begin
            mem_rd  = aluop;
            load_ac = aluop;
            inc_pc  = (opcode == OP_JMP);
            load_pc = (opcode == OP_JMP);
            mem_wr  = (opcode == OP_STO);
         end
         S_HALTED: halt = 1'b1;
         default: ;
      endcase
   end

   assign phase   = (state == S_HALTED) ? 3'd4 : state[2:0];
   assign stall   = access && !mem_ready;
   assign timeout = timeout_q;

endmodule

// File: doc/sm_controller_ws.md
# sm_controller_ws

Parametrised successor to the 8-phase accumulator-CPU control sequencer. It adds a memory wait-state handshake, a bounded-wait timeout, and a resumable halt state. It sits between the instruction register/ALU datapath and the memory port, and it drives all datapath load/increment/read/write strobes. Opcode encoding and the per-phase strobe decode match the existing controller, so the datapath needs no changes.

## Interface
Parameters:
- WAIT_MAX, 15: number of consecutive not-ready clock edges in one access phase that triggers a timeout. Legal range is 2..(2**CNT_W).
- CNT_W, 4: width of the wait counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  3  instruction opcode, valid from phase 3 onward. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator-zero flag.
- mem_ready  in  1  memory has completed the current access.
- resume  in  1  single-cycle request to leave an opcode halt.
- mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  out  1 each  datapath strobes.
- phase  out  3  current phase index. Reads 4 while halted.
- stall  out  1  an access phase is waiting on mem_ready.
- timeout  out  1  sticky memory-timeout flag.

## Operation
- State: phases 0..7 (INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE) plus HALTED. Also a CNT_W-bit wait counter and a timeout register.
- ALUOP is defined as opcode in {ADD, AND, XOR, LDA}.
- Strobe decode (Moore on state, qualified by opcode/zero; all strobes 0 unless listed):
  - 1: mem_rd.
  - 2, 3: mem_rd, load_ir.
  - 4: inc_pc; halt if HLT.
  - 5: mem_rd if ALUOP.
  - 6: mem_rd and load_ac if ALUOP; inc_pc if SKZ & zero; load_pc if JMP.
  - 7: mem_rd and load_ac if ALUOP; inc_pc and load_pc if JMP; mem_wr if STO.
  - HALTED: halt only.
- Access phases are phase 1 (always), phase 5 (if ALUOP) and phase 7 (if STO). All other phases advance unconditionally, and mem_ready is ignored in them.
- In an access phase:
  - mem_ready=1 at the edge: advance to the next phase and clear the counter.
  - mem_ready=0 and counter < WAIT_MAX-1: hold the phase, increment the counter, and hold all strobes unchanged.
  - mem_ready=0 and counter == WAIT_MAX-1: go to HALTED, set timeout=1, clear the counter.
- stall = access phase & ~mem_ready. It is purely combinational and never asserts outside an access phase.
- Phase 4 with HLT goes to HALTED instead of phase 5.
- Phase 7 wraps to phase 0.
- HALTED with timeout=0: resume=1 goes to phase 0. The PC was already incremented, so execution continues after the HLT.
- HALTED with timeout=1: resume is ignored. Only reset leaves this state.

## Timing
- Reset (rst=0) immediately forces, asynchronously:
  - phase 0, counter 0, timeout 0;
  - all strobes 0, stall 0, phase output 0.
- First advance happens on the first rising edge after rst returns high.
- Without stalls every instruction takes exactly 8 cycles, except HLT.
- Each not-ready edge in an access phase adds one cycle.
- A maximum of WAIT_MAX-1 stall cycles per access phase is tolerated. The WAIT_MAX-th consecutive not-ready edge times out.
- The counter restarts at 0 on entry to every phase, so stalls in phases 1, 5 and 7 are budgeted independently.
- HLT: halt is high from phase 4 onward, continuously through HALTED.
- resume sampled high in HALTED: phase 0 on the next cycle and halt drops.
- resume asserted outside HALTED has no effect.
- mem_wr on STO is held high for the full stall duration of phase 7. It drops on the edge where mem_ready=1 is sampled.
- Asynchronous reset during a stall or in HALTED behaves as normal reset and clears timeout.

## Test plan
- ADD, mem_ready=1, zero=0 -> phase runs 0..7 repeatedly, 8 cycles per instruction.
  - mem_rd high in phases 1,2,3,5,6,7.
  - load_ir high in phases 2,3.
  - inc_pc high in phase 4.
  - load_ac high in phases 6,7.
  - mem_wr never asserts.
- HLT -> halt=1 from phase 4, phase output stays 4.
  - resume pulsed 5 cycles later -> phase 0 next cycle, halt=0.
  - resume pulsed during phase 2 of the next instruction is ignored.
- ADD with mem_ready=0 for 3 edges in phase 1 -> stall=1 for 3 cycles, mem_rd held, instruction takes 11 cycles, timeout stays 0.
- STO with mem_ready=0 for 14 edges in phase 7, WAIT_MAX=15 -> mem_wr high 15 cycles, then phase 0.
  - Repeat with 15 low edges -> HALTED, timeout=1, halt=1.
  - resume is ignored.
  - rst=0 clears everything.
- SKZ zero=1 -> inc_pc in phases 4 and 6.
  - SKZ zero=0 -> inc_pc in phase 4 only.
  - JMP -> load_pc in phases 6,7 and inc_pc in phases 4,7.
- rst driven low mid-stall in phase 5 (LDA) -> all strobes and stall 0 before the next edge, phase 0.
  - Release rst -> normal 8-cycle sequence.
